// File: rtl/ym3438_dac_demux_if.sv
// Channel-output bus between the YM3438 core and its DAC demultiplexer:
// phase enable, channel value/strobe/sync, pan masks and the stereo sample result.
interface ym3438_dac_demux_if;
  logic        c1;
  logic [8:0]  ch_out;
  logic        dac_out_enable;
  logic        ch_sync;
  logic [5:0]  pan_l;
  logic [5:0]  pan_r;
  logic [15:0] out_l;
  logic [15:0] out_r;
  logic        out_valid;
  logic        sync_err;

  modport master (
    output c1, ch_out, dac_out_enable, ch_sync, pan_l, pan_r,
    input  out_l, out_r, out_valid, sync_err
  );

  modport slave (
    input  c1, ch_out, dac_out_enable, ch_sync, pan_l, pan_r,
    output out_l, out_r, out_valid, sync_err
  );
endinterface

// File: rtl/ym3438_dac_demux.sv
// Receive side of the YM3438 channel-output bus: slot tracking, per-channel pan and
// six-channel stereo summation. Define YM_DEMUX_LADDER_EN for YM2612 ladder-effect emulation.
module ym3438_dac_demux #(
  parameter int OUT_SHIFT = 4,
  parameter int NUM_CH    = 6
) (
  input logic              MCLK,
  input logic              reset,
  ym3438_dac_demux_if.slave bus
);

`ifdef YM_DEMUX_LADDER_EN
  localparam int ACC_W = 13;
`else
  localparam int ACC_W = 12;
`endif
  localparam int SLOT_W = $clog2(NUM_CH);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_CH - 1);

  typedef enum logic {
    UNLOCKED,
    RUN
  } state_t;

  state_t                   state_q, state_d;
  logic [SLOT_W-1:0]        slot_q, slot_d;
  logic signed [ACC_W-1:0]  acc_l_q, acc_l_d;
  logic signed [ACC_W-1:0]  acc_r_q, acc_r_d;
  logic [15:0]              out_l_q, out_l_d;
  logic [15:0]              out_r_q, out_r_d;
  logic                     out_valid_q, out_valid_d;
  logic                     sync_err_q, sync_err_d;

  logic                     cap;
  logic                     take;
  logic [SLOT_W-1:0]        eff_slot;
  logic signed [ACC_W-1:0]  s_ext;
  logic signed [ACC_W-1:0]  base_l, base_r;
  logic signed [ACC_W-1:0]  sum_l, sum_r;

  // Per-slot contribution of one channel to one side of the mix.
  function automatic logic signed [ACC_W-1:0] contrib(input logic on,
                                                      input logic signed [ACC_W-1:0] s);
`ifdef YM_DEMUX_LADDER_EN
    if (on) return s[ACC_W-1] ? s - ACC_W'(3) : s + ACC_W'(4);
    else    return s[ACC_W-1] ? ACC_W'(-4)    : ACC_W'(4);
`else
    return on ? s : '0;
`endif
  endfunction

  function automatic logic [15:0] scale(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W+3:0] wide;
    wide = {{4{a[ACC_W-1]}}, a};
    wide = wide <<< OUT_SHIFT;
`ifdef YM_DEMUX_LADDER_EN
    if (wide > 17'sd32767)       return 16'h7FFF;
    else if (wide < -17'sd32768) return 16'h8000;
    else                         return wide[15:0];
`else
    return wide;
`endif
  endfunction

  // Offset binary to two's complement is just an MSB flip.
  assign s_ext    = {{(ACC_W-8){~bus.ch_out[8]}}, bus.ch_out[7:0]};
  assign cap      = bus.c1 & bus.dac_out_enable;
  assign take     = cap & ((state_q == RUN) | bus.ch_sync);
  assign eff_slot = bus.ch_sync ? '0 : slot_q;

  // NOTE: every signal driven here gets a default first, so no path leaves a latch.
  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    acc_l_d     = acc_l_q;
    acc_r_d     = acc_r_q;
    out_l_d     = out_l_q;
    out_r_d     = out_r_q;
    out_valid_d = 1'b0;
    sync_err_d  = sync_err_q;

    // Slot 0 always starts from zero, which also discards a partial frame on resync.
    base_l = (eff_slot == '0) ? '0 : acc_l_q;
    base_r = (eff_slot == '0) ? '0 : acc_r_q;
    sum_l  = base_l + contrib(bus.pan_l[eff_slot], s_ext);
    sum_r  = base_r + contrib(bus.pan_r[eff_slot], s_ext);

    if (take) begin
      state_d = RUN;
      if (bus.ch_sync && (state_q == RUN) && (slot_q != '0)) sync_err_d = 1'b1;
      if (eff_slot == LAST_SLOT) begin
        out_l_d     = scale(sum_l);
        out_r_d     = scale(sum_r);
        out_valid_d = 1'b1;
        acc_l_d     = '0;
        acc_r_d     = '0;
        slot_d      = '0;
      end else begin
        acc_l_d = sum_l;
        acc_r_d = sum_r;
        slot_d  = eff_slot + SLOT_W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge MCLK) begin
    if (reset) begin
      state_q     <= UNLOCKED;
      slot_q      <= '0;
      acc_l_q     <= '0;
      acc_r_q     <= '0;
      out_l_q     <= '0;
      out_r_q     <= '0;
      out_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      acc_l_q     <= acc_l_d;
      acc_r_q     <= acc_r_d;
      out_l_q     <= out_l_d;
      out_r_q     <= out_r_d;
      out_valid_q <= out_valid_d;
      sync_err_q  <= sync_err_d;
    end
  end

  assign bus.out_l     = out_l_q;
  assign bus.out_r     = out_r_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sync_err  = sync_err_q;

endmodule

// File: tb/tb_ym3438_dac_demux.sv
// Scoreboard bench for ym3438_dac_demux: frames are modelled when driven and compared
// when out_valid fires; out_valid itself is checked every cycle.
module tb_ym3438_dac_demux;
  localparam int OUT_SHIFT = 4;

  logic mclk  = 1'b0;
  logic reset = 1'b1;
  always #5 mclk = ~mclk;

  ym3438_dac_demux_if bus ();

  ym3438_dac_demux #(.OUT_SHIFT(OUT_SHIFT), .NUM_CH(6)) dut (
    .MCLK  (mclk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  always @(posedge mclk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Independent model: offset binary value is simply code - 256.
  function automatic logic [15:0] model_out(input logic [53:0] vals, input logic [5:0] pan);
    int sum = 0;
    for (int i = 0; i < 6; i++) begin
      int s = int'(vals[i*9 +: 9]) - 256;
`ifdef YM_DEMUX_LADDER_EN
      if (pan[i]) sum += (s >= 0) ? s + 4 : s - 3;
      else        sum += (s >= 0) ? 4 : -4;
`else
      if (pan[i]) sum += s;
`endif
    end
    sum = sum * (1 << OUT_SHIFT);
    if (sum > 32767)  sum = 32767;
    if (sum < -32768) sum = -32768;
    return 16'(sum);
  endfunction

  always @(negedge mclk) begin : monitor
    exp_t e;
    logic exp_v;
    exp_v = (sb.size() > 0) && (sb[0].cyc + 1 == cyc);
    check("out_valid", {31'd0, bus.out_valid}, {31'd0, exp_v});
    if (exp_v) begin
      e = sb.pop_front();
      check("out_l", {16'd0, bus.out_l}, {16'd0, e.l});
      check("out_r", {16'd0, bus.out_r}, {16'd0, e.r});
    end
  end

  task automatic drive(input logic c1, input logic en, input logic [8:0] v, input logic sync,
                       input logic [5:0] pl, input logic [5:0] pr);
    @(negedge mclk);
    bus.c1             = c1;
    bus.dac_out_enable = en;
    bus.ch_out         = v;
    bus.ch_sync        = sync;
    bus.pan_l          = pl;
    bus.pan_r          = pr;
  endtask

  // Non-capture cycles alternate the two half-enables and wave ch_sync, all to be ignored.
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      if (k % 2 == 0) drive(1'b0, 1'b1, 9'($urandom), 1'b1, bus.pan_l, bus.pan_r);
      else            drive(1'b1, 1'b0, 9'($urandom), 1'b1, bus.pan_l, bus.pan_r);
    end
  endtask

  task automatic cap(input logic [8:0] v, input logic sync, input logic [5:0] pl,
                     input logic [5:0] pr);
    drive(1'b1, 1'b1, v, sync, pl, pr);
  endtask

  // One frame; first capture carries ch_sync unless first_sync is 0.
  task automatic send_frame(input logic [53:0] vals, input logic [5:0] pl,
                            input logic [5:0] pr, input int gap, input logic first_sync);
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      if (gap > 0 && i > 0) idle($urandom_range(0, gap));
      cap(vals[i*9 +: 9], (i == 0) ? first_sync : 1'b0, pl, pr);
      if (i == 5) begin
        e.l   = model_out(vals, pl);
        e.r   = model_out(vals, pr);
        e.cyc = cyc;
        sb.push_back(e);
      end
    end
    idle(2);
  endtask

  task automatic do_reset(input logic with_cap);
    @(negedge mclk);
    reset              = 1'b1;
    bus.c1             = with_cap;
    bus.dac_out_enable = with_cap;
    bus.ch_sync        = with_cap;
    bus.ch_out         = 9'h180;
    @(negedge mclk);
    check("rst_out_l", {16'd0, bus.out_l}, 32'd0);
    check("rst_out_r", {16'd0, bus.out_r}, 32'd0);
    check("rst_sync_err", {31'd0, bus.sync_err}, 32'd0);
    reset              = 1'b0;
    bus.c1             = 1'b0;
    bus.dac_out_enable = 1'b0;
  endtask

  initial begin
    logic [53:0] v;
    bus.c1 = 1'b0; bus.dac_out_enable = 1'b0; bus.ch_out = 9'h100;
    bus.ch_sync = 1'b0; bus.pan_l = 6'h00; bus.pan_r = 6'h00;
    repeat (2) @(negedge mclk);
    do_reset(1'b0);

    // All +128, both pans on, with gated cycles between captures.
    send_frame({6{9'h180}}, 6'h3F, 6'h3F, 2, 1'b1);
    idle(4);
    check("hold_l", {16'd0, bus.out_l}, 32'h3000);
    check("hold_r", {16'd0, bus.out_r}, 32'h3000);
    check("no_err", {31'd0, bus.sync_err}, 32'd0);

    send_frame({{5{9'h100}}, 9'h080}, 6'h01, 6'h00, 1, 1'b1);
    send_frame({6{9'h1FF}}, 6'h3F, 6'h3F, 0, 1'b1);
    send_frame({6{9'h000}}, 6'h3F, 6'h3F, 0, 1'b1);
    send_frame({6{9'h100}}, 6'h00, 6'h00, 0, 1'b1);
    check("still_no_err", {31'd0, bus.sync_err}, 32'd0);

    // Unlocked: captures without ch_sync are ignored.
    do_reset(1'b0);
    for (int i = 0; i < 7; i++) cap(9'h1FF, 1'b0, 6'h3F, 6'h3F);
    idle(2);
    check("unlocked_out_l", {16'd0, bus.out_l}, 32'd0);

    // Resync at slot 3; the resync sample starts a new frame as slot 0.
    cap(9'h1FF, 1'b1, 6'h3F, 6'h3F);
    cap(9'h1FF, 1'b0, 6'h3F, 6'h3F);
    cap(9'h1FF, 1'b0, 6'h3F, 6'h3F);
    send_frame({9'h190, 9'h0A0, 9'h100, 9'h1C0, 9'h050, 9'h123}, 6'h2B, 6'h15, 1, 1'b1);
    check("sync_err_set", {31'd0, bus.sync_err}, 32'd1);
    send_frame({9'h111, 9'h022, 9'h1EE, 9'h0DD, 9'h133, 9'h044}, 6'h3F, 6'h0C, 0, 1'b1);
    check("sync_err_sticky", {31'd0, bus.sync_err}, 32'd1);

    // Slot-5 capture with ch_sync resyncs instead of completing.
    do_reset(1'b0);
    cap(9'h180, 1'b1, 6'h3F, 6'h3F);
    for (int i = 0; i < 4; i++) cap(9'h180, 1'b0, 6'h3F, 6'h3F);
    send_frame({9'h101, 9'h102, 9'h103, 9'h104, 9'h105, 9'h0F0}, 6'h3F, 6'h3F, 0, 1'b1);
    check("slot5_sync_err", {31'd0, bus.sync_err}, 32'd1);

    // Reset mid-frame at slot 2, with a simultaneous sync capture that must lose.
    cap(9'h1FF, 1'b1, 6'h3F, 6'h3F);
    cap(9'h1FF, 1'b0, 6'h3F, 6'h3F);
    do_reset(1'b1);
    for (int i = 0; i < 6; i++) cap(9'h1FF, 1'b0, 6'h3F, 6'h3F);
    idle(2);
    check("post_rst_out_l", {16'd0, bus.out_l}, 32'd0);
    send_frame({6{9'h080}}, 6'h3F, 6'h2A, 1, 1'b1);

    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 6; i++) v[i*9 +: 9] = 9'($urandom);
      send_frame(v, 6'($urandom), 6'($urandom), 2, 1'b1);
    end

    idle(4);
    check("sb_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/ym3438_dac_demux.md
Name: ym3438_dac_demux

Overview:
- Receive side of the YM3438 channel-output bus.
- Captures the time-multiplexed 9-bit offset-binary channel values driven on the channel output together with its DAC-output strobe.
- Tracks the channel slot and applies per-channel L/R pan.
- Sums the six channels into signed 16-bit stereo samples for the MD audio mixer, with one output strobe per complete six-channel frame.

Parameters:
- OUT_SHIFT, 4, left shift applied to the 12-bit frame sum to form the 16-bit output (must be 0..4).
- NUM_CH, 6, channel slots per frame (fixed at 6 for YM3438; other values unsupported).

Ports:
- MCLK  in  1  master clock, all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- c1  in  1  phase enable; inputs sampled only on MCLK edges where c1=1.
- ch_out  in  9  channel value, offset binary (bit8 inverted two's complement).
- dac_out_enable  in  1  high = ch_out holds a valid channel value this phase.
- ch_sync  in  1  high together with a capture = this value is channel 1 (slot 0).
- pan_l  in  6  bit n = channel n+1 routed to left.
- pan_r  in  6  bit n = channel n+1 routed to right.
- out_l  out  16  signed left sample, held between frames.
- out_r  out  16  signed right sample, held between frames.
- out_valid  out  1  one-MCLK pulse when out_l/out_r update.
- sync_err  out  1  sticky; ch_sync arrived at a slot other than 0.

Behaviour:
- Capture event: cap = c1 & dac_out_enable, evaluated at a MCLK posedge. Non-capture cycles change no state except clearing out_valid.
- Sample conversion: s = {~ch_out[8], ch_out[7:0]} as 9-bit two's complement, range -256..+255. Example: 9'h100 -> 0, 9'h180 -> +128, 9'h080 -> -128.
- FSM state UNLOCKED (reset state):
  - Captures without ch_sync are ignored.
  - A capture with ch_sync goes to RUN; that sample is processed as slot 0.
- FSM state RUN:
  - slot counter 0..5; each capture processes the sample at the current slot, then slot = slot+1.
  - A capture with ch_sync forces processing as slot 0.
- Per-slot accumulation:
  - acc_l += pan_l[slot] ? sext12(s) : 0; acc_r likewise with pan_r.
  - Pan bits are sampled on the capture cycle.
  - acc_l/acc_r are 12-bit signed, range -1536..+1530; no overflow is possible.
- Frame completion, on the slot-5 capture:
  - Next MCLK: out_l = (acc_l including slot 5) <<< OUT_SHIFT, sign-extended to 16 bits; out_r the same; out_valid=1 for exactly one MCLK.
  - Accumulators clear; slot wraps to 0.
  - Latency from slot-5 capture to out_valid is 1 MCLK.
- Resync: ch_sync on a capture while in RUN with slot != 0:
  - sync_err <= 1 (sticky until reset).
  - The partial frame is discarded with no out_valid; accumulators restart from this sample as slot 0.
- ch_sync at slot 0 in RUN: normal, no error.
- Slot 5 capture with ch_sync asserted: treated as resync (slot 0), not as frame completion.
- Reset at any time, including mid-frame:
  - Next edge: state=UNLOCKED, slot=0, acc=0, out_l=out_r=0, out_valid=0, sync_err=0.
  - Reset dominates a simultaneous capture.
- out_l/out_r hold their value until the next completed frame.

Optional Feature:
- Macro: YM_DEMUX_LADDER_EN.
- Defined: YM2612 ladder-effect emulation. Each slot adds a crossover term to both accumulators:
  - Panned-on channel contributes s+4 if s>=0, else s-3.
  - Panned-off channel contributes +4 if s>=0, else -4.
  - Accumulators widen to 13 bits; the output is saturated to 16 bits after the shift.
- Undefined: pure sum as above; no ladder logic is synthesised.

Test Plan:
- Reset, ch_sync with first capture, six captures of 9'h180 with c1 gating, pan_l=pan_r=6'h3F -> one out_valid pulse 1 MCLK after 6th capture; out_l=out_r=16'h3000 (+12288); sync_err=0.
- pan_l=6'h01, pan_r=0; ch1=9'h080, ch2-6=9'h100 -> out_l=16'hF800 (-2048), out_r=16'h0000.
- Extremes, all pans on: six 9'h1FF -> out_l=out_r=24480 (16'h5FA0); six 9'h000 -> 16'hA000 (-24576).
- Captures before any ch_sync, then ch_sync at slot 3 of a running frame -> no output while UNLOCKED; sync_err=1; no out_valid for the broken frame; next clean 6-capture frame produces a correct out_valid.
- dac_out_enable=1 with c1=0, and c1=1 with dac_out_enable=0 -> no slot advance, outputs unchanged. Reset asserted mid-frame (slot 2) -> all outputs 0, state UNLOCKED, next frame needs ch_sync.
- With YM_DEMUX_LADDER_EN: pan=0, six 9'h100 -> out_l=out_r=24*16=384; without the macro the same stimulus -> 0.
